peripheral_io_responder: RTL and testbench



---
 rtl/peripheral_io_pkg.sv | 32 +++
 rtl/io_sync_fifo.sv | 60 ++++++
 rtl/peripheral_io_responder.sv | 180 ++++++++++++++++++
 tb/tb_peripheral_io_responder.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/peripheral_io_pkg.sv
// Shared constants for the peripheral I/O responder: request opcodes,
// response types, FSM state encoding and status word bit positions.
package peripheral_io_pkg;

  // Request opcodes on to_peripheral
  localparam logic [1:0] OP_NOP    = 2'b00;
  localparam logic [1:0] OP_WRITE  = 2'b01;
  localparam logic [1:0] OP_READ   = 2'b10;
  localparam logic [1:0] OP_STATUS = 2'b11;

  // Response types on from_peripheral
  localparam logic [1:0] RSP_NONE   = 2'b00;
  localparam logic [1:0] RSP_DATA   = 2'b01;
  localparam logic [1:0] RSP_STATUS = 2'b10;
  localparam logic [1:0] RSP_ERROR  = 2'b11;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // Status word layout
  localparam int unsigned STAT_TX_FULL    = 0;
  localparam int unsigned STAT_TX_EMPTY   = 1;
  localparam int unsigned STAT_RX_FULL    = 2;
  localparam int unsigned STAT_RX_EMPTY   = 3;
  localparam int unsigned STAT_DROP       = 4;
  localparam int unsigned STAT_RX_CNT_LSB = 8;
  localparam int unsigned STAT_TX_CNT_LSB = 16;
  localparam int unsigned STAT_CNT_W      = 8;

endpackage

// File: rtl/io_sync_fifo.sv
// Synchronous FIFO with occupancy count, used for both TX and RX buffering.
// Ports: clock, reset (sync, active-high); push/push_data write side;
// pop read side with head_c showing the oldest entry; full_c, empty_c and
// count (FIFO_DEPTH_LOG2+1 bits) report occupancy.
module io_sync_fifo #(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  logic [DATA_WIDTH-1:0]      push_data,
  input  logic                       pop,
  output logic [DATA_WIDTH-1:0]      head_c,
  output logic                       full_c,
  output logic                       empty_c,
  output logic [FIFO_DEPTH_LOG2:0]   count
);
  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned PTR_W = FIFO_DEPTH_LOG2;
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  do_push;
  logic                  do_pop;

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(DEPTH));
  assign head_c  = mem[rd_ptr];

  // A pop on empty is ignored (no bypass); a push on full is allowed only
  // alongside a real pop, keeping the count unchanged.
  assign do_pop  = pop && !empty_c;
  assign do_push = push && (!full_c || do_pop);

  // Pointers wrap naturally at the power-of-two depth
  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Storage, not reset
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/peripheral_io_responder.sv
// Peripheral-side endpoint of the core's to_peripheral/from_peripheral
// interface. Core WRITEs fill a TX FIFO drained by the device stream; device
// words fill an RX FIFO drained by core READs (blocking, with timeout).
// STATUS returns FIFO flags/counts and a sticky drop flag.
// Ports: clock, reset (sync, active-high); to_peripheral* request in;
// from_peripheral* registered response out; tx_data/tx_valid/tx_ready device
// TX stream; rx_data/rx_valid/rx_ready device RX stream.
// Build option: PERIPH_LOOPBACK_EN routes TX FIFO output into the RX FIFO and
// disables the external streams.
module peripheral_io_responder
  import peripheral_io_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned FIFO_DEPTH_LOG2 = 3,
  parameter int unsigned WAIT_TIMEOUT    = 64
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic [1:0]            to_peripheral,
  input  logic [DATA_WIDTH-1:0] to_peripheral_data,
  input  logic                  to_peripheral_valid,
  output logic [1:0]            from_peripheral,
  output logic [DATA_WIDTH-1:0] from_peripheral_data,
  output logic                  from_peripheral_valid,
  output logic [DATA_WIDTH-1:0] tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  input  logic [DATA_WIDTH-1:0] rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready
);
  localparam int unsigned CNT_W = FIFO_DEPTH_LOG2 + 1;
  localparam int unsigned TMO_W = $clog2(WAIT_TIMEOUT + 1);

  state_e                state_q, state_d;
  logic [TMO_W-1:0]      wait_cnt_q, wait_cnt_d;
  logic                  drop_q, drop_d;
  logic                  resp_valid_q, resp_valid_d;
  logic [1:0]            resp_type_q, resp_type_d;
  logic [DATA_WIDTH-1:0] resp_data_q, resp_data_d;

  logic                  tx_push, tx_pop, tx_full, tx_empty;
  logic                  rx_push, rx_pop, rx_full, rx_empty;
  logic [CNT_W-1:0]      tx_count, rx_count;
  logic [DATA_WIDTH-1:0] tx_head, rx_head, rx_push_data;
  logic [DATA_WIDTH-1:0] status_word;
  logic                  tmo_hit;

  io_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_tx_fifo (
    .clock(clock), .reset(reset),
    .push(tx_push), .push_data(to_peripheral_data),
    .pop(tx_pop), .head_c(tx_head),
    .full_c(tx_full), .empty_c(tx_empty), .count(tx_count)
  );

  io_sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_rx_fifo (
    .clock(clock), .reset(reset),
    .push(rx_push), .push_data(rx_push_data),
    .pop(rx_pop), .head_c(rx_head),
    .full_c(rx_full), .empty_c(rx_empty), .count(rx_count)
  );

  assign tx_data = tx_head;

`ifdef PERIPH_LOOPBACK_EN
  // TX drains straight into RX whenever RX has room
  logic unused_ext;
  assign unused_ext   = ^{rx_data, rx_valid, tx_ready};
  assign tx_pop       = !tx_empty && !rx_full;
  assign rx_push      = tx_pop;
  assign rx_push_data = tx_head;
  assign tx_valid     = 1'b0;
  assign rx_ready     = 1'b0;
`else
  // External device streams
  assign tx_valid     = !tx_empty;
  assign tx_pop       = tx_ready && !tx_empty;
  assign rx_ready     = !rx_full;
  assign rx_push      = rx_valid && !rx_full;
  assign rx_push_data = rx_data;
`endif

  // Status snapshot from pre-edge FIFO state
  always_comb begin
    status_word                                   = '0;
    status_word[STAT_TX_FULL]                     = tx_full;
    status_word[STAT_TX_EMPTY]                    = tx_empty;
    status_word[STAT_RX_FULL]                     = rx_full;
    status_word[STAT_RX_EMPTY]                    = rx_empty;
    status_word[STAT_DROP]                        = drop_q;
    status_word[STAT_RX_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(rx_count);
    status_word[STAT_TX_CNT_LSB +: STAT_CNT_W]    = STAT_CNT_W'(tx_count);
  end

  // Timeout fires on the wait cycle whose incremented count reaches WAIT_TIMEOUT-1
  assign tmo_hit = (wait_cnt_q + TMO_W'(1)) == TMO_W'(WAIT_TIMEOUT - 1);

  // Next-state and response decode
  always_comb begin
    state_d      = state_q;
    wait_cnt_d   = wait_cnt_q;
    drop_d       = drop_q;
    resp_valid_d = 1'b0;
    resp_type_d  = resp_type_q;
    resp_data_d  = resp_data_q;
    tx_push      = 1'b0;
    rx_pop       = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (to_peripheral_valid) begin
          case (to_peripheral)
            OP_WRITE: begin
              if (!tx_full) tx_push = 1'b1;
              else          drop_d  = 1'b1;
            end
            OP_READ: begin
              if (!rx_empty) begin
                rx_pop       = 1'b1;
                resp_valid_d = 1'b1;
                resp_type_d  = RSP_DATA;
                resp_data_d  = rx_head;
              end else begin
                state_d    = ST_WAIT;
                wait_cnt_d = '0;
              end
            end
            OP_STATUS: begin
              resp_valid_d = 1'b1;
              resp_type_d  = RSP_STATUS;
              resp_data_d  = status_word;
              drop_d       = 1'b0;
            end
            default: ;
          endcase
        end
      end
      ST_WAIT: begin
        wait_cnt_d = wait_cnt_q + TMO_W'(1);
        if (to_peripheral_valid && (to_peripheral != OP_NOP)) drop_d = 1'b1;
        if (!rx_empty) begin
          rx_pop       = 1'b1;
          resp_valid_d = 1'b1;
          resp_type_d  = RSP_DATA;
          resp_data_d  = rx_head;
          state_d      = ST_IDLE;
        end else if (tmo_hit) begin
          resp_valid_d = 1'b1;
          resp_type_d  = RSP_ERROR;
          resp_data_d  = '0;
          state_d      = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and response registers
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      wait_cnt_q   <= '0;
      drop_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_type_q  <= RSP_NONE;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      wait_cnt_q   <= wait_cnt_d;
      drop_q       <= drop_d;
      resp_valid_q <= resp_valid_d;
      resp_type_q  <= resp_type_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign from_peripheral       = resp_type_q;
  assign from_peripheral_data  = resp_data_q;
  assign from_peripheral_valid = resp_valid_q;

endmodule

// File: tb/tb_peripheral_io_responder.sv
// Self-checking bench for peripheral_io_responder: queue-based reference
// model compared against the DUT after every clock edge, plus directed
// scenarios with hand-computed expectations, then randomized traffic.
module tb_peripheral_io_responder;
  import peripheral_io_pkg::*;

  localparam int unsigned DW    = 32;
  localparam int unsigned DEPTH = 8;
  localparam int unsigned TMO   = 64;

  logic          clock = 1'b0;
  logic          reset;
  logic [1:0]    to_peripheral;
  logic [DW-1:0] to_peripheral_data;
  logic          to_peripheral_valid;
  logic [1:0]    from_peripheral;
  logic [DW-1:0] from_peripheral_data;
  logic          from_peripheral_valid;
  logic [DW-1:0] tx_data;
  logic          tx_valid;
  logic          tx_ready;
  logic [DW-1:0] rx_data;
  logic          rx_valid;
  logic          rx_ready;

  int tests = 0;
  int fails = 0;

  // Reference model state
  logic [DW-1:0] tx_q[$];
  logic [DW-1:0] rx_q[$];
  bit            m_wait = 1'b0;
  bit            m_drop = 1'b0;
  int unsigned   m_read_edge = 0;
  int unsigned   edge_n = 0;
  logic          m_valid = 1'b0;
  logic [1:0]    m_type = 2'b00;
  logic [DW-1:0] m_data = '0;

  peripheral_io_responder #(
    .DATA_WIDTH(DW), .FIFO_DEPTH_LOG2(3), .WAIT_TIMEOUT(TMO)
  ) dut (
    .clock(clock), .reset(reset),
    .to_peripheral(to_peripheral), .to_peripheral_data(to_peripheral_data),
    .to_peripheral_valid(to_peripheral_valid),
    .from_peripheral(from_peripheral), .from_peripheral_data(from_peripheral_data),
    .from_peripheral_valid(from_peripheral_valid),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
  );

  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", nm, act, want, edge_n);
    end
  endtask

  function automatic logic [DW-1:0] status_of(input int unsigned txn, input int unsigned rxn,
                                              input bit drop);
    logic [DW-1:0] w;
    w        = '0;
    w[0]     = (txn == DEPTH);
    w[1]     = (txn == 0);
    w[2]     = (rxn == DEPTH);
    w[3]     = (rxn == 0);
    w[4]     = drop;
    w[15:8]  = 8'(rxn);
    w[23:16] = 8'(txn);
    return w;
  endfunction

  // Advance the model by one clock edge using the inputs currently applied
  task automatic model_edge();
    int unsigned   txn;
    int unsigned   rxn;
    bit            tx_go;
    bit            rx_go;
    bit            wr_push;
    bit            rd_pop;
    logic [DW-1:0] rx_in;
    if (reset) begin
      tx_q.delete();
      rx_q.delete();
      m_wait  = 1'b0;
      m_drop  = 1'b0;
      m_valid = 1'b0;
      m_type  = 2'b00;
      m_data  = '0;
    end else begin
      txn     = tx_q.size();
      rxn     = rx_q.size();
      wr_push = 1'b0;
      rd_pop  = 1'b0;
      m_valid = 1'b0;
`ifdef PERIPH_LOOPBACK_EN
      tx_go = (txn > 0) && (rxn < DEPTH);
      rx_go = tx_go;
      rx_in = tx_go ? tx_q[0] : '0;
`else
      tx_go = tx_ready && (txn > 0);
      rx_go = rx_valid && (rxn < DEPTH);
      rx_in = rx_data;
`endif
      if (!m_wait) begin
        if (to_peripheral_valid) begin
          if (to_peripheral == OP_WRITE) begin
            if (txn < DEPTH) wr_push = 1'b1;
            else             m_drop  = 1'b1;
          end else if (to_peripheral == OP_READ) begin
            if (rxn > 0) begin
              m_valid = 1'b1; m_type = 2'b01; m_data = rx_q[0]; rd_pop = 1'b1;
            end else begin
              m_wait = 1'b1; m_read_edge = edge_n;
            end
          end else if (to_peripheral == OP_STATUS) begin
            m_valid = 1'b1; m_type = 2'b10; m_data = status_of(txn, rxn, m_drop);
            m_drop  = 1'b0;
          end
        end
      end else begin
        if (to_peripheral_valid && to_peripheral != OP_NOP) m_drop = 1'b1;
        if (rxn > 0) begin
          m_valid = 1'b1; m_type = 2'b01; m_data = rx_q[0]; rd_pop = 1'b1;
          m_wait  = 1'b0;
        end else if (edge_n - m_read_edge == TMO - 1) begin
          m_valid = 1'b1; m_type = 2'b11; m_data = '0;
          m_wait  = 1'b0;
        end
      end
      if (tx_go)   void'(tx_q.pop_front());
      if (wr_push) tx_q.push_back(to_peripheral_data);
      if (rd_pop)  void'(rx_q.pop_front());
      if (rx_go)   rx_q.push_back(rx_in);
    end
    edge_n++;
  endtask

  task automatic compare_all();
    bit want_txv;
    bit want_rxr;
`ifdef PERIPH_LOOPBACK_EN
    want_txv = 1'b0;
    want_rxr = 1'b0;
`else
    want_txv = (tx_q.size() > 0);
    want_rxr = (tx_q.size() >= 0) && (rx_q.size() < DEPTH);
`endif
    chk("resp_valid", DW'(from_peripheral_valid), DW'(m_valid));
    chk("resp_type",  DW'(from_peripheral), DW'(m_type));
    chk("resp_data",  from_peripheral_data, m_data);
    chk("tx_valid",   DW'(tx_valid), DW'(want_txv));
    chk("rx_ready",   DW'(rx_ready), DW'(want_rxr));
    if (want_txv) chk("tx_data", tx_data, tx_q[0]);
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic req(input logic [1:0] op, input logic [DW-1:0] d);
    to_peripheral       = op;
    to_peripheral_data  = d;
    to_peripheral_valid = 1'b1;
    step();
    to_peripheral_valid = 1'b0;
    to_peripheral       = OP_NOP;
  endtask

  task automatic wait_resp(input int budget, output int n);
    n = 0;
    while (!from_peripheral_valid && n < budget) begin
      step();
      n++;
    end
  endtask

  initial begin
    int n;
    reset               = 1'b1;
    to_peripheral       = OP_NOP;
    to_peripheral_data  = '0;
    to_peripheral_valid = 1'b0;
    tx_ready            = 1'b0;
    rx_data             = '0;
    rx_valid            = 1'b0;
    repeat (10) step();
    reset = 1'b0;

    // Status right after reset: tx_empty | rx_empty
    req(OP_STATUS, '0);
    chk("rst_status_valid", DW'(from_peripheral_valid), 32'd1);
    chk("rst_status_type",  DW'(from_peripheral), 32'd2);
    chk("rst_status_word",  from_peripheral_data, 32'h0000_000A);

`ifndef PERIPH_LOOPBACK_EN
    // Write and drain
    tx_ready = 1'b1;
    req(OP_WRITE, 32'h1234_5678);
    chk("drain_first", tx_data, 32'h1234_5678);
    req(OP_WRITE, 32'hDEAD_BEEF);
    chk("drain_second", tx_data, 32'hDEAD_BEEF);
    step();
    chk("drain_empty", DW'(tx_valid), 32'd0);

    // TX overflow: 9 writes with the device stalled
    tx_ready = 1'b0;
    for (int i = 0; i < 9; i++) req(OP_WRITE, 32'h100 + DW'(i));
    req(OP_STATUS, '0);
    chk("ovf_status1", from_peripheral_data, 32'h0008_0019);
    req(OP_STATUS, '0);
    chk("ovf_status2", from_peripheral_data, 32'h0008_0009);
    tx_ready = 1'b1;
    chk("ovf_head", tx_data, 32'h0000_0100);
    repeat (10) step();

    // Buffered read
    rx_valid = 1'b1; rx_data = 32'hCAFE_F00D;
    step();
    rx_valid = 1'b0;
    req(OP_READ, '0);
    chk("bufrd_valid", DW'(from_peripheral_valid), 32'd1);
    chk("bufrd_type",  DW'(from_peripheral), 32'd1);
    chk("bufrd_data",  from_peripheral_data, 32'hCAFE_F00D);
    step();

    // Blocking read that times out
    req(OP_READ, '0);
    wait_resp(200, n);
    chk("tmo_latency", DW'(n + 1), DW'(TMO));
    chk("tmo_type",    DW'(from_peripheral), 32'd3);
    chk("tmo_data",    from_peripheral_data, 32'd0);
    step();

    // Blocking read satisfied by a late device push
    req(OP_READ, '0);
    repeat (4) step();
    rx_valid = 1'b1; rx_data = 32'h55;
    step();
    rx_valid = 1'b0;
    chk("late_not_yet", DW'(from_peripheral_valid), 32'd0);
    step();
    chk("late_valid", DW'(from_peripheral_valid), 32'd1);
    chk("late_type",  DW'(from_peripheral), 32'd1);
    chk("late_data",  from_peripheral_data, 32'h55);
    step();
`else
    // Loopback: written word comes back through the RX FIFO
    req(OP_WRITE, 32'hA5A5_A5A5);
    req(OP_READ, '0);
    wait_resp(20, n);
    chk("lb_type",     DW'(from_peripheral), 32'd1);
    chk("lb_data",     from_peripheral_data, 32'hA5A5_A5A5);
    chk("lb_tx_valid", DW'(tx_valid), 32'd0);
    step();
`endif

    // Randomized traffic, second half with sparse device pushes to force timeouts
    for (int i = 0; i < 3000; i++) begin
      reset               = ($urandom_range(0, 299) == 0);
      to_peripheral_valid = ($urandom_range(0, 2) != 0);
      to_peripheral       = 2'($urandom_range(0, 3));
      to_peripheral_data  = $urandom;
      tx_ready            = (i < 1500) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      rx_valid            = (i < 1500) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 60) == 0);
      rx_data             = $urandom;
      step();
    end
    reset = 1'b0; to_peripheral_valid = 1'b0; rx_valid = 1'b0; tx_ready = 1'b1;
    reset = 1'b1; step(); reset = 1'b0;

    // Reset while waiting aborts with no response
    req(OP_READ, '0);
    repeat (3) step();
    reset = 1'b1; step(); reset = 1'b0;
    repeat (80) step();
    chk("rstwait_valid", DW'(from_peripheral_valid), 32'd0);
    chk("rstwait_type",  DW'(from_peripheral), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
